relu_maxpool2: RTL and testbench

Post-normalization stage placed directly downstream of the second batch-norm layer. It reads the normalized int8 feature map (CHANNELS × HEIGHT × WIDTH, channel-major) from the batch-norm output BRAM. For each channel it applies ReLU and 2×2/stride-2 max pooling, then writes the HEIGHT/2 × WIDTH/2 result per channel into the pooled-feature BRAM consumed by the next convolution layer. Processing is a single start-triggered pass with a done flag, in the same style as the neighbouring layer controllers.

---
 rtl/relu_maxpool_pkg.sv | 35 +++
 rtl/pool_addr_gen.sv | 85 ++++++++
 rtl/relu_maxpool2.sv | 135 +++++++++++++
 tb/tb_relu_maxpool2.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_maxpool_pkg.sv
// Shared types and default geometry for the ReLU + 2x2 max-pool stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package relu_maxpool_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    DRAIN,
    WR,
    DONE
  } state_t;

  // Default geometry of the layer this stage sits behind.
  localparam int DATA_WIDTH_DEF     = 8;
  localparam int CHANNELS_DEF       = 64;
  localparam int HEIGHT_DEF         = 14;
  localparam int WIDTH_DEF          = 16;
  localparam int IN_ADDR_WIDTH_DEF  = 14;
  localparam int OUT_ADDR_WIDTH_DEF = 12;

  // Derived sizes for the default geometry.
  localparam int OH        = HEIGHT_DEF / 2;
  localparam int OW        = WIDTH_DEF / 2;
  localparam int PIX_IN    = HEIGHT_DEF * WIDTH_DEF;
  localparam int PIX_OUT   = OH * OW;
  localparam int TOTAL_OUT = CHANNELS_DEF * PIX_OUT;

  // Offset of tap k from the top-left tap of a 2x2 window:
  // k=0 (0,0), k=1 (0,1), k=2 (1,0), k=3 (1,1).
  function automatic int tap_offset(input logic [1:0] k, input int width);
    return (k[1] ? width : 0) + (k[0] ? 1 : 0);
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window/output counters producing input tap and output write addresses.
// Latency: addresses are registers, valid the cycle after clear/advance.
// Backpressure: none; advances only when the controller asks.
module pool_addr_gen
  import relu_maxpool_pkg::*;
#(
  parameter int CHANNELS       = CHANNELS_DEF,
  parameter int HEIGHT         = HEIGHT_DEF,
  parameter int WIDTH          = WIDTH_DEF,
  parameter int IN_ADDR_WIDTH  = IN_ADDR_WIDTH_DEF,
  parameter int OUT_ADDR_WIDTH = OUT_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      tap_adv,
  input  logic                      out_adv,
  output logic [1:0]                k,
  output logic [IN_ADDR_WIDTH-1:0]  in_addr,
  output logic [OUT_ADDR_WIDTH-1:0] out_addr,
  output logic                      last
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int YW = (HEIGHT / 2 > 1) ? $clog2(HEIGHT / 2) : 1;
  localparam int XW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;

  localparam logic [CW-1:0] CH_MAX = CW'(CHANNELS - 1);
  localparam logic [YW-1:0] OY_MAX = YW'(HEIGHT / 2 - 1);
  localparam logic [XW-1:0] OX_MAX = XW'(WIDTH / 2 - 1);

  // Moving one window right skips 2 columns; leaving the last window of a
  // row pair skips the second row as well. Channels are stored back to back,
  // so the channel wrap uses the same row-pair step.
  localparam logic [IN_ADDR_WIDTH-1:0] STEP_COL = IN_ADDR_WIDTH'(2);
  localparam logic [IN_ADDR_WIDTH-1:0] STEP_ROW = IN_ADDR_WIDTH'(WIDTH + 2);

  logic [CW-1:0]            ch;
  logic [YW-1:0]            oy;
  logic [XW-1:0]            ox;
  logic [IN_ADDR_WIDTH-1:0] base;
  logic [IN_ADDR_WIDTH-1:0] base_next;

  assign last = (ch == CH_MAX) && (oy == OY_MAX) && (ox == OX_MAX);

  // Top-left tap address of the next window.
  always_comb begin
    base_next = base + STEP_COL;
    if (ox == OX_MAX) base_next = base + STEP_ROW;
    if (last)         base_next = '0;
  end

  // Counter and address registers.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      k        <= 2'd0;
      ch       <= '0;
      oy       <= '0;
      ox       <= '0;
      base     <= '0;
      in_addr  <= '0;
      out_addr <= '0;
    end else if (out_adv) begin
      k        <= 2'd0;
      base     <= base_next;
      in_addr  <= base_next;
      out_addr <= last ? '0 : out_addr + OUT_ADDR_WIDTH'(1);
      if (ox == OX_MAX) begin
        ox <= '0;
        if (oy == OY_MAX) begin
          oy <= '0;
          ch <= (ch == CH_MAX) ? '0 : ch + CW'(1);
        end else begin
          oy <= oy + YW'(1);
        end
      end else begin
        ox <= ox + XW'(1);
      end
    end else if (tap_adv) begin
      k       <= k + 2'd1;
      in_addr <= base + IN_ADDR_WIDTH'(tap_offset(k + 2'd1, WIDTH));
    end
  end

endmodule

// File: rtl/relu_maxpool2.sv
// ReLU + 2x2/stride-2 max pool from batch-norm BRAM into pooled-feature BRAM.
// Latency: 6 cycles per output pixel (4 reads, 1 drain, 1 write); done the cycle after the last write.
// Backpressure: none; fixed-rate BRAM access, start ignored while busy.
module relu_maxpool2
  import relu_maxpool_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int CHANNELS       = CHANNELS_DEF,
  parameter int HEIGHT         = HEIGHT_DEF,
  parameter int WIDTH          = WIDTH_DEF,
  parameter int IN_ADDR_WIDTH  = IN_ADDR_WIDTH_DEF,
  parameter int OUT_ADDR_WIDTH = OUT_ADDR_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         in_en,
  output logic [IN_ADDR_WIDTH-1:0]     in_addr,
  input  logic signed [DATA_WIDTH-1:0] in_rdata,
  output logic                         out_en,
  output logic                         out_we,
  output logic [OUT_ADDR_WIDTH-1:0]    out_addr,
  output logic [DATA_WIDTH-1:0]        out_wdata
);

  if (HEIGHT % 2 != 0) begin : g_bad_height
    $error("relu_maxpool2: HEIGHT must be even");
  end
  if (WIDTH % 2 != 0) begin : g_bad_width
    $error("relu_maxpool2: WIDTH must be even");
  end
  if (IN_ADDR_WIDTH < $clog2(CHANNELS * HEIGHT * WIDTH)) begin : g_bad_in_aw
    $error("relu_maxpool2: IN_ADDR_WIDTH too small");
  end
  if (OUT_ADDR_WIDTH < $clog2(CHANNELS * HEIGHT * WIDTH / 4)) begin : g_bad_out_aw
    $error("relu_maxpool2: OUT_ADDR_WIDTH too small");
  end

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] max_r;
  logic signed [DATA_WIDTH-1:0] tap_max;
  logic [1:0]                   k;
  logic                         last;
  logic                         clear;
  logic                         tap_adv;
  logic                         out_adv;

  // Counter controls: restart on an accepted start, step taps through the
  // read burst, step to the next window on the write cycle.
  always_comb begin
    clear   = ((state == IDLE) || (state == DONE)) && start;
    tap_adv = (state == RD) && (k != 2'd3);
    out_adv = (state == WR);
  end

  // Running maximum including the tap arriving this cycle.
  always_comb begin
    tap_max = (in_rdata > max_r) ? in_rdata : max_r;
  end

  pool_addr_gen #(
    .CHANNELS      (CHANNELS),
    .HEIGHT        (HEIGHT),
    .WIDTH         (WIDTH),
    .IN_ADDR_WIDTH (IN_ADDR_WIDTH),
    .OUT_ADDR_WIDTH(OUT_ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .tap_adv (tap_adv),
    .out_adv (out_adv),
    .k       (k),
    .in_addr (in_addr),
    .out_addr(out_addr),
    .last    (last)
  );

  // Pass controller with registered strobes; read data lags in_en by one
  // cycle, so tap k is captured during RD k+1 and tap 3 during DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      in_en     <= 1'b0;
      out_en    <= 1'b0;
      out_we    <= 1'b0;
      out_wdata <= '0;
      max_r     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RD;
            busy  <= 1'b1;
            done  <= 1'b0;
            in_en <= 1'b1;
          end
        end
        RD: begin
          if (k == 2'd1)      max_r <= in_rdata;
          else if (k != 2'd0) max_r <= tap_max;
          if (k == 2'd3) begin
            state <= DRAIN;
            in_en <= 1'b0;
          end
        end
        DRAIN: begin
          max_r     <= tap_max;
          out_en    <= 1'b1;
          out_we    <= 1'b1;
          out_wdata <= tap_max[DATA_WIDTH-1] ? '0 : tap_max;
          state     <= WR;
        end
        WR: begin
          out_en <= 1'b0;
          out_we <= 1'b0;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= RD;
            in_en <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_maxpool2.sv
// Self-checking bench for relu_maxpool2 with a BRAM model and a window-level reference.
// Latency: n/a.
// Backpressure: n/a.
module tb_relu_maxpool2;

  localparam int DW       = 8;
  localparam int CH       = 64;
  localparam int H        = 14;
  localparam int W        = 16;
  localparam int IAW      = 14;
  localparam int OAW      = 12;
  localparam int OHT      = H / 2;
  localparam int OWT      = W / 2;
  localparam int TOTAL    = CH * OHT * OWT;
  localparam int NIN      = CH * H * W;
  localparam int DONE_LAT = 21505;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic                 busy, done, in_en, out_en, out_we;
  logic [IAW-1:0]       in_addr;
  logic [OAW-1:0]       out_addr;
  logic [DW-1:0]        out_wdata;
  logic signed [DW-1:0] in_rdata = '0;

  logic signed [DW-1:0] mem [NIN];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int cyc0   = 0;

  int rd_log[$];
  int rd_cyc[$];
  int wr_addr[$];
  int wr_dat[$];
  int wr_cyc[$];
  int exp_dat[TOTAL];
  int exp_rd[4*TOTAL];
  int saved[TOTAL];

  relu_maxpool2 #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .HEIGHT(H), .WIDTH(W),
    .IN_ADDR_WIDTH(IAW), .OUT_ADDR_WIDTH(OAW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_en(in_en), .in_addr(in_addr), .in_rdata(in_rdata),
    .out_en(out_en), .out_we(out_we), .out_addr(out_addr), .out_wdata(out_wdata)
  );

  always #5 clk = ~clk;

  // Cycle counter and synchronous-read input BRAM.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_en) in_rdata <= mem[in_addr];
  end

  // Record every read and write away from the clock edge.
  always @(negedge clk) begin
    if (in_en) begin
      rd_log.push_back(int'(in_addr));
      rd_cyc.push_back(cyc);
    end
    if (out_we) begin
      wr_addr.push_back(int'(out_addr));
      wr_dat.push_back(int'(out_wdata));
      wr_cyc.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    rd_log.delete(); rd_cyc.delete();
    wr_addr.delete(); wr_dat.delete(); wr_cyc.delete();
  endtask

  task automatic fill_random();
    for (int i = 0; i < NIN; i++) mem[i] = DW'($urandom);
  endtask

  // Reference: walk windows in output order, max over 4 taps, clamp at 0.
  task automatic build_model();
    int o, a, m, v;
    o = 0;
    for (int c = 0; c < CH; c++)
      for (int y = 0; y < OHT; y++)
        for (int x = 0; x < OWT; x++) begin
          m = -1000;
          for (int t = 0; t < 4; t++) begin
            a = c * H * W + (2 * y + t / 2) * W + 2 * x + t % 2;
            exp_rd[4*o+t] = a;
            v = int'(mem[a]);
            if (v > m) m = v;
          end
          exp_dat[o] = (m < 0) ? 0 : m;
          o++;
        end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cyc0 = cyc;
  endtask

  task automatic wait_done(input int budget, output int when);
    int i;
    when = -1;
    i = 0;
    while (when < 0 && i < budget) begin
      @(negedge clk);
      if (done) when = cyc;
      i++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (in_en !== 1'b0) begin errors++; $display("FAIL reset_in_en got %b want 0", in_en); end
    checks++; if (in_addr !== '0) begin errors++; $display("FAIL reset_in_addr got %0d want 0", in_addr); end
    checks++; if (out_en !== 1'b0) begin errors++; $display("FAIL reset_out_en got %b want 0", out_en); end
    checks++; if (out_we !== 1'b0) begin errors++; $display("FAIL reset_out_we got %b want 0", out_we); end
    checks++; if (out_addr !== '0) begin errors++; $display("FAIL reset_out_addr got %0d want 0", out_addr); end
    checks++; if (out_wdata !== '0) begin errors++; $display("FAIL reset_out_wdata got %0d want 0", out_wdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || in_en !== 1'b0) begin errors++; $display("FAIL idle_quiet busy=%b in_en=%b want 0 0", busy, in_en); end
  endtask

  task automatic test_directed_taps();
    int e_dat[3];
    int e_rd[4];
    int i;
    e_dat = '{7, 0, 127};
    e_rd  = '{0, 1, 16, 17};
    fill_random();
    mem[0] = -8'sd5;   mem[1] = 8'sd3;    mem[16] = 8'sd7;   mem[17] = -8'sd2;
    mem[2] = -8'sd128; mem[3] = -8'sd1;   mem[18] = -8'sd50; mem[19] = -8'sd3;
    mem[4] = 8'sd127;  mem[5] = 8'sd127;  mem[20] = 8'sd0;   mem[21] = 8'sd0;
    clear_logs();
    pulse_start();
    checks++; if (in_en !== 1'b1 || in_addr !== '0) begin errors++; $display("FAIL first_read in_en=%b in_addr=%0d want 1 0", in_en, in_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_after_start got %b want 1", busy); end
    i = 0;
    while (wr_addr.size() < 3 && i < 100) begin @(negedge clk); i++; end
    checks++;
    if (wr_addr.size() < 3) begin
      errors++; $display("FAIL directed_writes got %0d want 3", wr_addr.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++; if (wr_dat[j] !== e_dat[j]) begin errors++; $display("FAIL directed_value[%0d] got %0d want %0d", j, wr_dat[j], e_dat[j]); end
        checks++; if (wr_addr[j] !== j) begin errors++; $display("FAIL directed_addr[%0d] got %0d want %0d", j, wr_addr[j], j); end
      end
      for (int j = 0; j < 4; j++) begin
        checks++; if (rd_log[j] !== e_rd[j] || rd_cyc[j] !== cyc0 + j) begin
          errors++; $display("FAIL directed_tap[%0d] addr %0d at %0d want %0d at %0d", j, rd_log[j], rd_cyc[j], e_rd[j], cyc0 + j);
        end
      end
      checks++; if (wr_cyc[0] !== cyc0 + 5) begin errors++; $display("FAIL first_write_cycle got %0d want %0d", wr_cyc[0] - cyc0, 5); end
      checks++; if (wr_cyc[1] - wr_cyc[0] !== 6) begin errors++; $display("FAIL write_spacing got %0d want 6", wr_cyc[1] - wr_cyc[0]); end
    end
  endtask

  // Continues the directed pass: reset lands on the edge that would open the
  // write cycle of output 10.
  task automatic test_rst_mid_pass();
    int i;
    i = 0;
    while (cyc < cyc0 + 64 && i < 200) begin @(negedge clk); i++; end
    checks++; if (cyc !== cyc0 + 64) begin errors++; $display("FAIL rst_align got %0d want %0d", cyc - cyc0, 64); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_we !== 1'b0 || out_en !== 1'b0) begin errors++; $display("FAIL rst_write_blocked out_we=%b out_en=%b want 0 0", out_we, out_en); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || in_en !== 1'b0) begin errors++; $display("FAIL rst_ctrl busy=%b done=%b in_en=%b want 0 0 0", busy, done, in_en); end
    checks++; if (in_addr !== '0 || out_addr !== '0 || out_wdata !== '0) begin
      errors++; $display("FAIL rst_addr in_addr=%0d out_addr=%0d wdata=%0d want 0 0 0", in_addr, out_addr, out_wdata);
    end
    checks++; if (wr_addr.size() !== 10) begin errors++; $display("FAIL rst_write_count got %0d want 10", wr_addr.size()); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_pass();
    int i, when;
    fill_random();
    build_model();
    clear_logs();
    pulse_start();
    checks++; if (in_en !== 1'b1 || in_addr !== '0) begin errors++; $display("FAIL restart_addr in_en=%b in_addr=%0d want 1 0", in_en, in_addr); end
    i = 0;
    while (cyc < cyc0 + 99 && i < 200) begin @(negedge clk); i++; end
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_pass got %b want 1", busy); end
    wait_done(30000, when);
    checks++; if (when < 0 || when - cyc0 + 1 !== DONE_LAT) begin
      errors++; $display("FAIL done_latency got %0d want %0d", (when < 0) ? -1 : when - cyc0 + 1, DONE_LAT);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b want 0", busy); end
    checks++; if (wr_addr.size() !== TOTAL) begin errors++; $display("FAIL write_count got %0d want %0d", wr_addr.size(), TOTAL); end
    checks++; if (rd_log.size() !== 4 * TOTAL) begin errors++; $display("FAIL read_count got %0d want %0d", rd_log.size(), 4 * TOTAL); end
    if (wr_addr.size() == TOTAL && rd_log.size() == 4 * TOTAL) begin
      for (int o = 0; o < TOTAL; o++) begin
        checks++; if (wr_addr[o] !== o || wr_dat[o] !== exp_dat[o] || wr_cyc[o] !== cyc0 + 6 * o + 5) begin
          errors++; $display("FAIL pass_write[%0d] addr %0d data %0d t %0d want %0d %0d %0d",
                             o, wr_addr[o], wr_dat[o], wr_cyc[o] - cyc0, o, exp_dat[o], 6 * o + 5);
        end
        saved[o] = wr_dat[o];
      end
      for (int j = 0; j < 4 * TOTAL; j++) begin
        checks++; if (rd_log[j] !== exp_rd[j] || rd_cyc[j] !== cyc0 + 6 * (j / 4) + j % 4) begin
          errors++; $display("FAIL pass_read[%0d] addr %0d t %0d want %0d %0d",
                             j, rd_log[j], rd_cyc[j] - cyc0, exp_rd[j], 6 * (j / 4) + j % 4);
        end
      end
      checks++; if (wr_addr[56] !== 56 || rd_log[224] !== 224) begin
        errors++; $display("FAIL wrap_channel out_addr %0d tap0 %0d want 56 224", wr_addr[56], rd_log[224]);
      end
      checks++; if (wr_addr[15] !== 15 || rd_log[60] !== 46 || rd_log[61] !== 47 || rd_log[62] !== 62 || rd_log[63] !== 63) begin
        errors++; $display("FAIL wrap_row out_addr %0d taps %0d %0d %0d %0d want 15 46 47 62 63",
                           wr_addr[15], rd_log[60], rd_log[61], rd_log[62], rd_log[63]);
      end
    end
  endtask

  task automatic test_restart_from_done();
    int when;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_held got %b want 1", done); end
    clear_logs();
    pulse_start();
    checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL restart_flags done=%b busy=%b want 0 1", done, busy); end
    wait_done(30000, when);
    checks++; if (when < 0) begin errors++; $display("FAIL second_pass_done got timeout want done"); end
    checks++; if (wr_addr.size() !== TOTAL) begin errors++; $display("FAIL second_write_count got %0d want %0d", wr_addr.size(), TOTAL); end
    if (wr_addr.size() == TOTAL) begin
      for (int o = 0; o < TOTAL; o++) begin
        checks++; if (wr_addr[o] !== o || wr_dat[o] !== saved[o] || wr_dat[o] !== exp_dat[o]) begin
          errors++; $display("FAIL second_pass[%0d] addr %0d data %0d want %0d %0d", o, wr_addr[o], wr_dat[o], o, exp_dat[o]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed_taps();
    test_rst_mid_pass();
    test_full_pass();
    test_restart_from_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
